// File: rtl/cordic_pkg.sv
// Shared types and constants for the vectoring-mode CORDIC engine.
//   cordic_state_e : control FSM states
//   atan_lsb(i, w) : round(atan(2^-i) * 2^w / 2pi), i in 0..31
//   inv_gain(w)    : round(0.607252935 * 2^w), reciprocal of the CORDIC gain
//   angle_pi(w)    : half a turn, 2^(w-1)
// Tables are held at 32-bit resolution and rounded to the requested width;
// widths above 32 are left-shifted, so they carry no extra precision.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROT   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } cordic_state_e;

    localparam int unsigned REF_W       = 32;
    localparam logic [63:0] INV_GAIN_32 = 64'd2608131496;

    // atan(2^-i) with a full turn equal to 2^32.
    function automatic logic [31:0] atan_32(input int unsigned i);
        logic [31:0] r;
        r = 32'd0;
        case (i)
            0:  r = 32'h2000_0000;
            1:  r = 32'h12E4_051E;
            2:  r = 32'h09FB_385B;
            3:  r = 32'h0511_11D4;
            4:  r = 32'h028B_0D43;
            5:  r = 32'h0145_D7E1;
            6:  r = 32'h00A2_F61E;
            7:  r = 32'h0051_7C55;
            8:  r = 32'h0028_BE53;
            9:  r = 32'h0014_5F2F;
            10: r = 32'h000A_2F98;
            11: r = 32'h0005_17CC;
            12: r = 32'h0002_8BE6;
            13: r = 32'h0001_45F3;
            14: r = 32'h0000_A2FA;
            15: r = 32'h0000_517D;
            16: r = 32'h0000_28BE;
            17: r = 32'h0000_145F;
            18: r = 32'h0000_0A30;
            19: r = 32'h0000_0518;
            20: r = 32'h0000_028C;
            21: r = 32'h0000_0146;
            22: r = 32'h0000_00A3;
            23: r = 32'h0000_0051;
            24: r = 32'h0000_0029;
            25: r = 32'h0000_0014;
            26: r = 32'h0000_000A;
            27: r = 32'h0000_0005;
            28: r = 32'h0000_0003;
            29: r = 32'h0000_0001;
            30: r = 32'h0000_0001;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Re-express a 2^32-scaled constant at 2^w scale, rounding to nearest.
    function automatic logic [63:0] rescale_32(input logic [63:0] v, input int unsigned w);
        if (w >= REF_W) begin
            return v << (w - REF_W);
        end
        return (v + (64'd1 << (REF_W - 1 - w))) >> (REF_W - w);
    endfunction

    function automatic logic [63:0] atan_lsb(input int unsigned i, input int unsigned w);
        return rescale_32({32'd0, atan_32(i)}, w);
    endfunction

    function automatic logic [63:0] inv_gain(input int unsigned w);
        return rescale_32(INV_GAIN_32, w);
    endfunction

    function automatic logic [63:0] angle_pi(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/cordic_vectoring_iter_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation.
//   x_i, y_i, z_i : current registered vector and accumulated angle
//   shift_i       : iteration index i (arithmetic shift amount)
//   atan_i        : ATAN[i] in binary angle units
//   x_c_o, y_c_o, z_c_o : rotated vector and updated angle (unregistered)
module cordic_vec_stage #(
    parameter int unsigned XW      = 22,
    parameter int unsigned ANGLE_W = 16,
    parameter int unsigned SHW     = 4
) (
    input  logic signed [XW-1:0]   x_i,
    input  logic signed [XW-1:0]   y_i,
    input  logic [ANGLE_W-1:0]     z_i,
    input  logic [SHW-1:0]         shift_i,
    input  logic [ANGLE_W-1:0]     atan_i,
    output logic signed [XW-1:0]   x_c_o,
    output logic signed [XW-1:0]   y_c_o,
    output logic [ANGLE_W-1:0]     z_c_o
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    // Rotate toward the x axis; direction chosen by the sign of y.
    always_comb begin
        x_sh  = x_i >>> shift_i;
        y_sh  = y_i >>> shift_i;
        x_c_o = x_i;
        y_c_o = y_i;
        z_c_o = z_i;
        if (!y_i[XW-1]) begin
            x_c_o = x_i + y_sh;
            y_c_o = y_i - x_sh;
            z_c_o = z_i + atan_i;
        end else begin
            x_c_o = x_i - y_sh;
            y_c_o = y_i + x_sh;
            z_c_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter: iterative vectoring-mode CORDIC, one micro-rotation
// per clock. Converts (x, y) to magnitude and atan2(y, x).
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only while idle)
//   x_in, y_in           : signed Cartesian operands
//   out_valid / out_ready: result handshake, result held until accepted
//   mag_out              : magnitude (times gain K unless compensated)
//   angle_out            : angle, full turn = 2^ANGLE_W
// Build option: define CORDIC_GAIN_COMP_EN to add a SCALE cycle that
// multiplies the magnitude by 1/K.
// The datapath carries GUARD extra fractional bits below the sign-extended
// WIDTH+2 integer part so that late iterations (large shifts) still steer
// correctly for small operands; the magnitude is rounded back on output.
module cordic_vectoring_iter
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ANGLE_W = 32,
    parameter int unsigned ITER    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH+1:0]        mag_out,
    output logic [ANGLE_W-1:0]      angle_out
);

    localparam int unsigned GUARD = (ITER > 2) ? $clog2(ITER) : 1;
    localparam int unsigned MW    = WIDTH + 2;
    localparam int unsigned XW    = MW + GUARD;
    localparam int unsigned XR    = XW + 1;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [CNT_W-1:0]       LAST = CNT_W'(ITER - 1);
    localparam logic [ANGLE_W-1:0]     PI_Z = ANGLE_W'(angle_pi(ANGLE_W));
    localparam logic signed [XR-1:0]   HALF = XR'(64'd1 << (GUARD - 1));

    cordic_state_e        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [XW-1:0] x_q, x_d;
    logic signed [XW-1:0] y_q, y_d;
    logic [ANGLE_W-1:0]   z_q, z_d;
    logic                 zero_q, zero_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [MW-1:0]        mag_q, mag_d;
    logic [ANGLE_W-1:0]   angle_q, angle_d;

    logic signed [XW-1:0] x_ext, y_ext;
    logic signed [XW-1:0] x_nxt, y_nxt;
    logic [ANGLE_W-1:0]   z_nxt;
    logic [ANGLE_W-1:0]   atan_cur;

    // Round the guarded datapath value back to integer magnitude units.
    function automatic logic [MW-1:0] round_mag(input logic signed [XW-1:0] v);
        logic signed [XR-1:0] t;
        t = XR'(v) + HALF;
        return MW'(t >>> GUARD);
    endfunction

    assign x_ext    = XW'(x_in) <<< GUARD;
    assign y_ext    = XW'(y_in) <<< GUARD;
    assign atan_cur = ANGLE_W'(atan_lsb(32'(cnt_q), ANGLE_W));

    cordic_vec_stage #(
        .XW      (XW),
        .ANGLE_W (ANGLE_W),
        .SHW     (CNT_W)
    ) u_stage (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (cnt_q),
        .atan_i  (atan_cur),
        .x_c_o   (x_nxt),
        .y_c_o   (y_nxt),
        .z_c_o   (z_nxt)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam int unsigned        PW    = XW + WIDTH;
    localparam logic [WIDTH-1:0]   INV_G = WIDTH'(inv_gain(WIDTH));

    logic [PW-1:0]        prod;
    logic signed [XW-1:0] x_scl;

    // x is non-negative after vectoring, so an unsigned product is exact.
    assign prod  = PW'($unsigned(x_q)) * PW'(INV_G);
    assign x_scl = $signed(XW'(prod >> WIDTH));
`endif

    // Next-state, datapath and output register inputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zero_d      = zero_q;
        mag_d       = mag_q;
        angle_d     = angle_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Fold the left half-plane onto the right by a half turn.
                    if (x_in[WIDTH-1]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = PI_Z;
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                    zero_d  = (x_in == '0) && (y_in == '0);
                    cnt_d   = '0;
                    state_d = ST_ROT;
                end
            end
            ST_ROT: begin
                x_d = x_nxt;
                y_d = y_nxt;
                z_d = z_nxt;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = ST_SCALE;
`else
                    state_d = ST_DONE;
                    mag_d   = zero_q ? '0 : round_mag(x_nxt);
                    angle_d = zero_q ? '0 : z_nxt;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SCALE: begin
`ifdef CORDIC_GAIN_COMP_EN
                x_d     = x_scl;
                mag_d   = zero_q ? '0 : round_mag(x_scl);
                angle_d = zero_q ? '0 : z_q;
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mag_q       <= '0;
            angle_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mag_q       <= mag_d;
            angle_q     <= angle_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign mag_out   = mag_q;
    assign angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed self-checking bench for cordic_vectoring_iter
// (WIDTH=16, ANGLE_W=16, ITER=16). Expected magnitudes and latency follow
// CORDIC_GAIN_COMP_EN when the macro is defined for the build.
module tb_cordic_vectoring_iter;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned ANGLE_W = 16;
    localparam int unsigned ITER    = 16;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int EXP_LAT = ITER + 2;
    localparam int MAG_1K  = 1000;
    localparam int MAG_D   = 1414;
    localparam int MAG_MAX = 32768;
`else
    localparam int EXP_LAT = ITER + 1;
    localparam int MAG_1K  = 1647;
    localparam int MAG_D   = 2329;
    localparam int MAG_MAX = 53962;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH+1:0]        mag_out;
    logic [ANGLE_W-1:0]      angle_out;

    int checks;
    int failures;

    cordic_vectoring_iter #(
        .WIDTH   (WIDTH),
        .ANGLE_W (ANGLE_W),
        .ITER    (ITER)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Angular distance modulo a full turn.
    function automatic int ang_err(input logic [15:0] a, input int e);
        logic [15:0] ev;
        logic signed [15:0] d;
        ev = 16'(e);
        d  = $signed(a - ev);
        return abs_i(int'(d));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and wait (bounded) for the result; lat counts
    // clock edges from the one that accepts the operand. 999 = no result.
    task automatic run_op(input int xv, input int yv, output int lat);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        x_in     = 16'(xv);
        y_in     = 16'(yv);
        lat      = 0;
        do begin
            tick();
            in_valid = 1'b0;
            lat++;
        end while (out_valid !== 1'b1 && lat < 64);
        if (out_valid !== 1'b1) lat = 999;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
        end
        checks++;
        if (mag_out !== '0 || angle_out !== '0) begin
            failures++;
            $display("FAIL reset_data: mag=%0d angle=%0d expected 0 0", mag_out, angle_out);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_early: in_ready=%b expected 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        int xs  [6] = '{1000, 0, -1000, 1000, -32768, 0};
        int ys  [6] = '{0, 1000, 0, -1000, 0, 0};
        int em  [6] = '{MAG_1K, MAG_1K, MAG_1K, MAG_D, MAG_MAX, 0};
        int ea  [6] = '{0, 16384, 32768, 57344, 32768, 0};
        int mt  [6] = '{2, 2, 2, 2, 3, 0};
        int at  [6] = '{4, 4, 4, 4, 4, 0};
        int lat;
        int me;
        int ae;
        for (int k = 0; k < 6; k++) begin
            run_op(xs[k], ys[k], lat);
            checks++;
            if (lat !== EXP_LAT) begin
                failures++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", k, lat, EXP_LAT);
            end
            me = int'(mag_out) - em[k];
            checks++;
            if (abs_i(me) > mt[k]) begin
                failures++;
                $display("FAIL vec%0d_mag: got %0d expected %0d +-%0d", k, mag_out, em[k], mt[k]);
            end
            ae = ang_err(angle_out, ea[k]);
            checks++;
            if (ae > at[k]) begin
                failures++;
                $display("FAIL vec%0d_angle: got %0d expected %0d +-%0d", k, angle_out, ea[k], at[k]);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL vec%0d_ready_while_valid: in_ready=%b expected 0", k, in_ready);
            end
            consume();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_consume: out_valid=%b in_ready=%b expected 0 1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        run_op(1000, -1000, lat);
        checks++;
        if (lat !== EXP_LAT) begin
            failures++;
            $display("FAIL hold_latency: got %0d expected %0d", lat, EXP_LAT);
        end
        for (int c = 0; c < 10; c++) begin
            // Busy-time operands must be ignored.
            in_valid = (c % 2) == 0;
            x_in     = 16'(0);
            y_in     = 16'(0);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d_flags: out_valid=%b in_ready=%b expected 1 0", c, out_valid, in_ready);
            end
            checks++;
            if (abs_i(int'(mag_out) - MAG_D) > 2 || ang_err(angle_out, 57344) > 4) begin
                failures++;
                $display("FAIL hold%0d_data: mag=%0d angle=%0d expected %0d 57344", c, mag_out, angle_out, MAG_D);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_consume: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        in_valid = 1'b1;
        x_in     = 16'(1000);
        y_in     = 16'(1000);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || mag_out !== '0 || angle_out !== '0) begin
            failures++;
            $display("FAIL midreset_state: rdy=%b vld=%b mag=%0d ang=%0d expected 0 0 0 0",
                     in_ready, out_valid, mag_out, angle_out);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_ready: in_ready=%b expected 1", in_ready);
        end
        seen = 0;
        for (int c = 0; c < ITER + 4; c++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midreset_no_result: out_valid cycles=%0d expected 0", seen);
        end
        run_op(0, 1000, lat);
        checks++;
        if (lat !== EXP_LAT || abs_i(int'(mag_out) - MAG_1K) > 2 || ang_err(angle_out, 16384) > 4) begin
            failures++;
            $display("FAIL midreset_next_op: lat=%0d mag=%0d angle=%0d expected %0d %0d 16384",
                     lat, mag_out, angle_out, EXP_LAT, MAG_1K);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(-1000, 0, lat);
        checks++;
        if (lat !== EXP_LAT || ang_err(angle_out, 32768) > 4) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d angle=%0d expected %0d 32768", lat, angle_out, EXP_LAT);
        end
        consume();
        run_op(1000, 0, lat);
        checks++;
        if (lat !== EXP_LAT || ang_err(angle_out, 0) > 4 || abs_i(int'(mag_out) - MAG_1K) > 2) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d mag=%0d angle=%0d expected %0d %0d 0",
                     lat, mag_out, angle_out, EXP_LAT, MAG_1K);
        end
        consume();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring_iter.md
Name: cordic_vectoring_iter

Overview:
- Iterative vectoring-mode CORDIC engine. It is the inverse direction of the existing rotation-mode shift-accumulate stages.
- Given a Cartesian vector (x, y), it drives y toward 0 over ITER micro-rotations.
- Returns magnitude (times the CORDIC gain) and the angle atan2(y, x) in binary angle units.
- Sits after the rotation datapath to recover polar form. Uses a valid/ready handshake on both sides and one micro-rotation per clock.

Parameters:
- WIDTH, 32, signed two's-complement width of x_in and y_in.
- ANGLE_W, 32, angle width; full circle = 2^ANGLE_W, so the angle wraps naturally.
- ITER, 16, micro-rotations per operation (1..ANGLE_W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  engine idle, can accept
- x_in  in  WIDTH  signed x
- y_in  in  WIDTH  signed y
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- mag_out  out  WIDTH+2  unsigned magnitude
- angle_out  out  ANGLE_W  angle, 0..2^ANGLE_W-1 maps to 0..2π

Behaviour:
- Reset: clk is single clock; rst_n is asynchronous active-low.
  - While rst_n is low: state=IDLE; in_ready=0; out_valid=0; mag_out=0; angle_out=0; iteration counter=0; internal x/y/z=0.
  - in_ready rises on the first clock edge after rst_n deasserts.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, load operands and go to ROT.
  - ROT: ITER cycles, counter i = 0..ITER-1. On i==ITER-1, go to SCALE if GAIN_COMP_EN is defined, else DONE.
  - SCALE: one cycle, then DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Load (accept cycle):
  - Sign-extend x_in and y_in to WIDTH+2 internal bits.
  - If x_in<0: x=-x_in, y=-y_in, z=2^(ANGLE_W-1) (π). Otherwise x=x_in, y=y_in, z=0.
  - Negating -2^(WIDTH-1) must not overflow; this is guaranteed by the internal width.
- Micro-rotation i, using arithmetic shifts of the current registered x and y:
  - If y>=0: x+=y>>>i; y-=x>>>i; z+=ATAN[i].
  - Else: x-=y>>>i; y+=x>>>i; z-=ATAN[i].
  - z arithmetic is modulo 2^ANGLE_W.
- ATAN[i] = round(atan(2^-i)·2^ANGLE_W/(2π)).
- Zero vector: if x_in==0 and y_in==0 at accept, a zero flag is set. Results are forced to mag_out=0 and angle_out=0 with the same latency as any other operation.
- Results: mag_out and angle_out update only on entry to DONE, and are held stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises ITER+1 clocks after the accept edge (ITER+2 with GAIN_COMP_EN).
- Throughput: one operation per ITER+2 cycles minimum.
- in_ready is 0 in every state except IDLE. Inputs arriving while busy are ignored.
- out_valid and in_ready are never both 1. A new operation is not accepted in the same cycle a result is consumed.
- Accuracy: angle within ±(ITER-dependent residual + 2) LSB of the ideal value. Magnitude equals K·|v| ±2 LSB, where K≈1.646760.
- Reset asserted mid-operation aborts immediately. No result is produced; state returns to the reset values above.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: the SCALE state multiplies x by the constant INV_GAIN = round(0.607252935·2^(WIDTH)) and takes the product >>WIDTH. mag_out ≈ |v| ±2 LSB. Latency is ITER+2.
- Undefined: the SCALE state and the multiplier are absent. mag_out = raw x (gain K included). Latency is ITER+1.

Decomposition:
- Package cordic_pkg holds:
  - the ATAN table function/constant, parameterised by ANGLE_W and generated for ITER entries;
  - ANGLE_PI = 2^(ANGLE_W-1);
  - the INV_GAIN constant;
  - the state enum (IDLE, ROT, SCALE, DONE).
- One natural sub-module: cordic_vec_stage. It is combinational and takes x, y, z, shift amount i and ATAN[i], producing the next x/y/z. The top level instantiates it once and iterates it.

Test Plan (WIDTH=16, ANGLE_W=16, ITER=16, CORDIC_GAIN_COMP_EN undefined):
- x=1000, y=0 -> angle_out 0 (±4), mag_out 1647 (±2), out_valid at accept+17.
- x=0, y=1000 -> angle 16384 (±4); x=-1000, y=0 -> angle 32768 (±4); both give mag 1647 (±2).
- x=1000, y=-1000 -> angle 57344 (±4), mag 2329 (±2).
- x=0, y=0 -> mag 0, angle 0 exactly, same latency.
- x=-32768, y=0 -> angle 32768 (±4), mag 53962 (±3); no overflow.
- Hold out_ready=0 for 10 cycles after a result: outputs stable and in_ready=0 throughout; in_valid pulses during that time are ignored. Pulse rst_n low at ROT i=5: out_valid never rises, in_ready=1 one cycle after release, and the next operation is correct.
- Repeat all cases with CORDIC_GAIN_COMP_EN defined: 1000,0 gives mag 1000 (±2); 1000,-1000 gives mag 1414 (±2); latency is 18.
